demod_accumulator: RTL and testbench

//  Downstream stage of the pulsed-wave Doppler core timing FSM. Samples the signed echo ADC word on each
//  RX sample strobe while DEMOD_ON is high; 4-phase quadrature mixing (+I,+Q,-I,-Q) into I/Q accumulators.
//  On each RETRANSMIT pulse (one per PRF period) the range-gate I/Q sum is latched to a valid/ready

---
 rtl/demod_accumulator_pkg.sv | 21 ++
 rtl/demod_accumulator_if.sv | 15 +
 rtl/demod_accumulator_rx_strobe_gen.sv | 30 +++
 rtl/demod_accumulator.sv | 127 ++++++++++++
 tb/tb_demod_accumulator.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/demod_accumulator_pkg.sv
// Shared types for the PW Doppler demod accumulator: carrier select codes and the
// quadrature mixing phase sequence.
package demod_accumulator_pkg;

  localparam logic [1:0] FREQ_8MHZ = 2'd0;
  localparam logic [1:0] FREQ_4MHZ = 2'd1;
  localparam logic [1:0] FREQ_2MHZ = 2'd2;

  // bit0 selects Q, bit1 selects subtraction
  typedef enum logic [1:0] {
    PH_POS_I = 2'd0,
    PH_POS_Q = 2'd1,
    PH_NEG_I = 2'd2,
    PH_NEG_Q = 2'd3
  } phase_e;

  function automatic phase_e phase_next(input phase_e p);
    return phase_e'(p + 2'd1);
  endfunction

endpackage

// File: rtl/demod_accumulator_if.sv
// Gate-result valid/ready channel from the demod accumulator to the Doppler filter stage.
interface demod_accumulator_if #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 10
);
  logic                    valid;
  logic                    ready;
  logic signed [ACC_W-1:0] i_sum;
  logic signed [ACC_W-1:0] q_sum;
  logic [CNT_W-1:0]        n;
  logic                    sat;

  modport master (output valid, i_sum, q_sum, n, sat, input ready);
  modport slave  (input valid, i_sum, q_sum, n, sat, output ready);
endinterface

// File: rtl/demod_accumulator_rx_strobe_gen.sv
// Sample strobe and phase-restart generation: every cycle at 8 MHz, otherwise on RX_CLK
// rising edges, always gated by the demod window.
module rx_strobe_gen
  import demod_accumulator_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_freq,
  input  logic       i_rx_clk,
  input  logic       i_demod_on,
  output logic       o_strobe,
  output logic       o_restart
);
  logic r_rx_q, r_demod_q;
  logic w_rx_rise;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_q    <= 1'b0;
      r_demod_q <= 1'b0;
    end else begin
      r_rx_q    <= i_rx_clk;
      r_demod_q <= i_demod_on;
    end
  end

  assign w_rx_rise = i_rx_clk & ~r_rx_q;
  assign o_strobe  = i_demod_on & ((i_freq == FREQ_8MHZ) | w_rx_rise);
  assign o_restart = i_demod_on & ~r_demod_q;
endmodule

// File: rtl/demod_accumulator.sv
// Range-gate I/Q accumulator: 4-phase quadrature mixing of ADC samples into saturating
// accumulators, latched to a valid/ready output two cycles after each RETRANSMIT.
module demod_accumulator
  import demod_accumulator_pkg::*;
#(
  parameter int ADC_W = 12,
  parameter int ACC_W = 24,
  parameter int CNT_W = 10
) (
  input  logic                    i_coreClock,
  input  logic                    i_reset,
  input  logic [1:0]              i_freq,
  input  logic                    i_rx_clk,
  input  logic                    i_demod_on,
  input  logic                    i_retransmit,
  input  logic signed [ADC_W-1:0] i_adc_data,
  demod_accumulator_if.master     o_res,
  output logic                    o_overrun
);
  localparam logic signed [ACC_W:0] MAXV = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {2'b11, {(ACC_W-1){1'b0}}};

  logic                    w_strobe, w_restart;
  phase_e                  w_ph_cur, r_phase, r_s1_ph;
  logic                    r_s1_vld;
  logic signed [ADC_W-1:0] r_s1_x;
  logic [1:0]              r_lat;
  logic signed [ACC_W-1:0] r_i, r_q, w_i_nxt, w_q_nxt;
  logic [CNT_W-1:0]        r_n, w_n_nxt;
  logic                    r_sat, w_sat_nxt;
  logic signed [ACC_W:0]   w_x, w_d;
  logic [ACC_W:0]          w_sum;
  logic                    r_vld, r_osat, r_ovr;
  logic signed [ACC_W-1:0] r_oi, r_oq;
  logic [CNT_W-1:0]        r_on;

  // Returns {clamped, value}; one extra bit of headroom makes the clamp test exact.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [ACC_W:0] d);
    logic signed [ACC_W:0] s;
    s = $signed({a[ACC_W-1], a}) + d;
    if (s > MAXV)      return {1'b1, MAXV[ACC_W-1:0]};
    else if (s < MINV) return {1'b1, MINV[ACC_W-1:0]};
    else               return {1'b0, s[ACC_W-1:0]};
  endfunction

  rx_strobe_gen u_strobe (
    .i_clk      (i_coreClock),
    .i_rst      (i_reset),
    .i_freq     (i_freq),
    .i_rx_clk   (i_rx_clk),
    .i_demod_on (i_demod_on),
    .o_strobe   (w_strobe),
    .o_restart  (w_restart)
  );

  assign w_ph_cur = w_restart ? PH_POS_I : r_phase;
  assign w_x      = (ACC_W+1)'(r_s1_x);
  assign w_d      = r_s1_ph[1] ? -w_x : w_x;
  assign w_sum    = sat_add(r_s1_ph[0] ? r_q : r_i, w_d);

  always_comb begin
    w_i_nxt   = r_i;
    w_q_nxt   = r_q;
    w_n_nxt   = r_n;
    w_sat_nxt = r_sat;
    if (r_s1_vld) begin
      if (r_s1_ph[0]) w_q_nxt = w_sum[ACC_W-1:0];
      else            w_i_nxt = w_sum[ACC_W-1:0];
      w_sat_nxt = r_sat | w_sum[ACC_W];
      if (r_n != '1) w_n_nxt = r_n + CNT_W'(1);
    end
  end

  always_ff @(posedge i_coreClock) begin
    if (i_reset) begin
      r_phase  <= PH_POS_I;
      r_s1_vld <= 1'b0;
      r_s1_x   <= '0;
      r_s1_ph  <= PH_POS_I;
      r_lat    <= '0;
      r_i      <= '0;
      r_q      <= '0;
      r_n      <= '0;
      r_sat    <= 1'b0;
      r_vld    <= 1'b0;
      r_oi     <= '0;
      r_oq     <= '0;
      r_on     <= '0;
      r_osat   <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_s1_vld <= w_strobe;
      r_s1_x   <= i_adc_data;
      r_s1_ph  <= w_ph_cur;
      if (w_strobe)       r_phase <= phase_next(w_ph_cur);
      else if (w_restart) r_phase <= PH_POS_I;
      r_lat <= {r_lat[0], i_retransmit};
      // Latch takes the S2 sample of this edge, then the gate restarts from zero
      if (r_lat[1]) begin
        r_i    <= '0;
        r_q    <= '0;
        r_n    <= '0;
        r_sat  <= 1'b0;
        r_vld  <= 1'b1;
        r_oi   <= w_i_nxt;
        r_oq   <= w_q_nxt;
        r_on   <= w_n_nxt;
        r_osat <= w_sat_nxt;
        if (r_vld && !o_res.ready) r_ovr <= 1'b1;
      end else begin
        r_i   <= w_i_nxt;
        r_q   <= w_q_nxt;
        r_n   <= w_n_nxt;
        r_sat <= w_sat_nxt;
        if (r_vld && o_res.ready) r_vld <= 1'b0;
      end
    end
  end

  assign o_res.valid = r_vld;
  assign o_res.i_sum = r_oi;
  assign o_res.q_sum = r_oq;
  assign o_res.n     = r_on;
  assign o_res.sat   = r_osat;
  assign o_overrun   = r_ovr;
endmodule

// File: tb/tb_demod_accumulator.sv
// Self-checking bench for demod_accumulator: table of gates plus hand-written
// reset, overrun and same-edge handshake sequences, checked through a scoreboard.
module tb_demod_accumulator;
  import demod_accumulator_pkg::*;

  localparam int ADC_W = 12;
  localparam int ACC_W = 14;
  localparam int CNT_W = 10;

  typedef struct {
    logic [1:0] freq;
    int         n;
    bit         pat;   // 0: base+k*step, 1: base on phase-0 samples only
    int         base;
    int         step;
    bit         lead;  // RETRANSMIT one sample before the last
    int         ei, eq, en;
    bit         esat;
  } vec_t;

  typedef struct { int i, q, n; bit sat; } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] freq = FREQ_8MHZ;
  logic rx = 1'b0, demod = 1'b0, ret = 1'b0;
  logic signed [ADC_W-1:0] adc = '0;
  logic ovr;

  demod_accumulator_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) res_if ();

  demod_accumulator #(.ADC_W(ADC_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .i_coreClock  (clk),
    .i_reset      (rst),
    .i_freq       (freq),
    .i_rx_clk     (rx),
    .i_demod_on   (demod),
    .i_retransmit (ret),
    .i_adc_data   (adc),
    .o_res        (res_if),
    .o_overrun    (ovr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  exp_t sb[$];
  vec_t vt[8];

  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  function automatic int samp(input vec_t v, input int k);
    if (v.pat) return (k % 4 == 0) ? v.base : 0;
    return v.base + k * v.step;
  endfunction

  // Output model: result due two edges after RETRANSMIT, handshake clears valid.
  initial begin
    bit d1 = 0, d2 = 0, lat, ev = 0, eov = 0, pv;
    exp_t e;
    res_if.ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      pv  = ev;
      lat = d2; d2 = d1; d1 = ret;
      if (rst) begin
        d1 = 0; d2 = 0; ev = 0; eov = 0;
        chk("rst_i", int'(res_if.i_sum), 0);
        chk("rst_q", int'(res_if.q_sum), 0);
        chk("rst_n", int'(res_if.n), 0);
        chk("rst_sat", int'(res_if.sat), 0);
      end else if (lat) begin
        eov = eov | (pv & ~res_if.ready);
        ev  = 1;
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("gate_i", int'(res_if.i_sum), e.i);
          chk("gate_q", int'(res_if.q_sum), e.q);
          chk("gate_n", int'(res_if.n), e.n);
          chk("gate_sat", int'(res_if.sat), int'(e.sat));
        end
      end else if (pv && res_if.ready) ev = 0;
      chk("out_valid", int'(res_if.valid), int'(ev));
      chk("overrun", int'(ovr), int'(eov));
    end
  end

  task automatic push(input int i, input int q, input int n, input bit s);
    exp_t e;
    e.i = i; e.q = q; e.n = n; e.sat = s;
    sb.push_back(e);
  endtask

  task automatic run_gate(input vec_t v);
    int h, nret;
    freq = v.freq; demod = 1'b0; rx = 1'b0; ret = 1'b0;
    repeat (2) @(negedge clk);
    h    = (v.freq == FREQ_4MHZ) ? 1 : 2;
    nret = v.n - 1 - int'(v.lead);
    for (int k = 0; k < v.n; k++) begin
      demod = 1'b1;
      adc   = ADC_W'(samp(v, k));
      if (k == nret) begin
        ret = 1'b1;
        push(v.ei, v.eq, v.en, v.esat);
      end
      if (v.freq == FREQ_8MHZ) @(negedge clk);
      else begin
        rx = 1'b1;
        @(negedge clk);
        ret = 1'b0;
        repeat (h - 1) @(negedge clk);
        rx = 1'b0;
        repeat (h) @(negedge clk);
      end
      ret = 1'b0;
    end
    demod = 1'b0;
    if (v.n == 0) begin
      ret = 1'b1;
      push(v.ei, v.eq, v.en, v.esat);
      @(negedge clk);
      ret = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    vt[0] = '{FREQ_4MHZ,  8, 1'b0,   100,    0, 1'b0,     0,   0,  8, 1'b0};
    vt[1] = '{FREQ_8MHZ,  4, 1'b0,    10,   10, 1'b0,   -20, -20,  4, 1'b0};
    vt[2] = '{FREQ_8MHZ,  4, 1'b0,    10,   10, 1'b1,   -20, -20,  4, 1'b0};
    vt[3] = '{FREQ_2MHZ,  5, 1'b0,    -7,    3, 1'b0,    -1,  -6,  5, 1'b0};
    vt[4] = '{FREQ_8MHZ, 20, 1'b1,  2047,    0, 1'b0,  8191,   0, 20, 1'b1};
    vt[5] = '{FREQ_8MHZ, 20, 1'b1, -2048,    0, 1'b0, -8192,   0, 20, 1'b1};
    vt[6] = '{FREQ_8MHZ,  0, 1'b0,     0,    0, 1'b0,     0,   0,  0, 1'b0};
    vt[7] = '{FREQ_8MHZ,  6, 1'b0,  1000, -300, 1'b0,   400, 100,  6, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vt[i]) run_gate(vt[i]);

    // New result arrives on the same edge the pending one is accepted
    res_if.ready = 1'b0;
    run_gate(vt[1]);
    freq = FREQ_8MHZ;
    demod = 1'b1; adc = 12'sd5; ret = 1'b1;
    push(5, 0, 1, 1'b0);
    @(negedge clk);
    demod = 1'b0; ret = 1'b0;
    @(negedge clk);
    res_if.ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_ovr_same_edge", int'(ovr), 0);

    // Two results with nobody reading: second overwrites, overrun sticks
    res_if.ready = 1'b0;
    run_gate(vt[7]);
    run_gate(vt[3]);
    chk("ovr_set", int'(ovr), 1);
    res_if.ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("ovr_sticky", int'(ovr), 1);

    // Reset mid-gate with a result pending: everything clears, partial sum discarded
    res_if.ready = 1'b0;
    run_gate(vt[1]);
    demod = 1'b1;
    for (int k = 0; k < 3; k++) begin
      adc = ADC_W'(300 + k);
      @(negedge clk);
    end
    rst = 1'b1; demod = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    res_if.ready = 1'b1;
    chk("ovr_after_rst", int'(ovr), 0);
    chk("valid_after_rst", int'(res_if.valid), 0);
    @(negedge clk);
    ret = 1'b1;
    push(0, 0, 0, 1'b0);
    @(negedge clk);
    ret = 1'b0;
    repeat (4) @(negedge clk);
    run_gate(vt[0]);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
